// File: rtl/axi_isolate_drain.sv
// axi_isolate_drain: AXI pass-through that caps outstanding bursts and drains them before isolating the port
package axi_isolate_drain_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ax_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_t;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_t;
  typedef struct packed {
    ax_t  aw;
    logic aw_valid;
    w_t   w;
    logic w_valid;
    logic b_ready;
    ax_t  ar;
    logic ar_valid;
    logic r_ready;
  } req_t;
  typedef struct packed {
    logic aw_ready;
    logic ar_ready;
    logic w_ready;
    b_t   b;
    logic b_valid;
    r_t   r;
    logic r_valid;
  } rsp_t;
endpackage

module axi_isolate_drain #(
  parameter int unsigned MaxTxns = 4,
  parameter type req_t = axi_isolate_drain_pkg::req_t,
  parameter type rsp_t = axi_isolate_drain_pkg::rsp_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic isolate_i,
  output logic isolated_o,
  input  req_t slv_req_i,
  output rsp_t slv_rsp_o,
  output req_t mst_req_o,
  input  rsp_t mst_rsp_i
);
  localparam int unsigned CW = $clog2(MaxTxns + 1);
  localparam logic [CW-1:0] MAX = CW'(MaxTxns);
  typedef enum logic [1:0] {NORMAL, DRAIN, ISOLATED} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] wr_cnt, rd_cnt, w_pend;
  logic aw_open, ar_open, w_open, aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs, idle;
  always_comb begin
    aw_open = state_q == NORMAL && wr_cnt < MAX && w_pend < MAX;
    ar_open = state_q == NORMAL && rd_cnt < MAX;
    w_open = w_pend != '0;
    mst_req_o = slv_req_i;
    mst_req_o.aw_valid = slv_req_i.aw_valid & aw_open;
    mst_req_o.ar_valid = slv_req_i.ar_valid & ar_open;
    mst_req_o.w_valid = slv_req_i.w_valid & w_open;
    slv_rsp_o = mst_rsp_i;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & aw_open;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & ar_open;
    slv_rsp_o.w_ready = mst_rsp_i.w_ready & w_open;
    aw_hs = mst_req_o.aw_valid & mst_rsp_i.aw_ready;
    ar_hs = mst_req_o.ar_valid & mst_rsp_i.ar_ready;
    w_last_hs = mst_req_o.w_valid & mst_rsp_i.w_ready & slv_req_i.w.last;
    b_hs = mst_rsp_i.b_valid & slv_req_i.b_ready;
    r_last_hs = mst_rsp_i.r_valid & slv_req_i.r_ready & mst_rsp_i.r.last;
    idle = wr_cnt == '0 && rd_cnt == '0 && w_pend == '0;
    // dropping isolate_i wins over completing the drain
    state_d = state_q == NORMAL ? (isolate_i ? DRAIN : NORMAL)
            : !isolate_i ? NORMAL
            : idle ? ISOLATED : state_q;
    isolated_o = state_q == ISOLATED;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= NORMAL;
      wr_cnt <= '0;
      rd_cnt <= '0;
      w_pend <= '0;
    end else begin
      state_q <= state_d;
      wr_cnt <= wr_cnt + CW'(aw_hs) - CW'(b_hs);
      rd_cnt <= rd_cnt + CW'(ar_hs) - CW'(r_last_hs);
      w_pend <= w_pend + CW'(aw_hs) - CW'(w_last_hs);
    end
  end
  wr_ovf: assert property (@(posedge clk_i) disable iff (rst_i) !(aw_hs && !b_hs && wr_cnt == MAX));
  wr_udf: assert property (@(posedge clk_i) disable iff (rst_i) !(b_hs && !aw_hs && wr_cnt == '0));
  rd_ovf: assert property (@(posedge clk_i) disable iff (rst_i) !(ar_hs && !r_last_hs && rd_cnt == MAX));
  rd_udf: assert property (@(posedge clk_i) disable iff (rst_i) !(r_last_hs && !ar_hs && rd_cnt == '0));
  wp_ovf: assert property (@(posedge clk_i) disable iff (rst_i) !(aw_hs && !w_last_hs && w_pend == MAX));
  wp_udf: assert property (@(posedge clk_i) disable iff (rst_i) !(w_last_hs && !aw_hs && w_pend == '0));
endmodule

// File: tb/tb_axi_isolate_drain.sv
// tb_axi_isolate_drain: directed stimulus with queue scoreboard for axi_isolate_drain
module tb_axi_isolate_drain;
  import axi_isolate_drain_pkg::*;
  logic clk = 1'b0;
  logic rst, isolate, isolated;
  req_t slv_req, mst_req;
  rsp_t slv_rsp, mst_rsp;
  int checks = 0;
  int errors = 0;
  ax_t exp_aw[$];
  ax_t exp_ar[$];
  w_t exp_w[$];
  b_t exp_b[$];
  r_t exp_r[$];

  always #5 clk = ~clk;

  axi_isolate_drain #(.MaxTxns(4)) dut (
    .clk_i(clk), .rst_i(rst), .isolate_i(isolate), .isolated_o(isolated),
    .slv_req_i(slv_req), .slv_rsp_o(slv_rsp), .mst_req_o(mst_req), .mst_rsp_i(mst_rsp)
  );

  task automatic cmp(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  function automatic ax_t ax(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    return '{id: id, addr: addr, len: len};
  endfunction
  function automatic w_t wb(input logic [31:0] data, input logic last);
    return '{data: data, strb: 4'hf, last: last};
  endfunction
  function automatic b_t bb(input logic [3:0] id);
    return '{id: id, resp: 2'b00};
  endfunction
  function automatic r_t rb(input logic [3:0] id, input logic [31:0] data, input logic last);
    return '{id: id, data: data, resp: 2'b00, last: last};
  endfunction

  // monitor: every handshake seen at either side of the DUT must match the oldest expectation
  always @(negedge clk) begin
    if (mst_req.aw_valid && mst_rsp.aw_ready) begin
      cmp("aw_avail", 64'(exp_aw.size() != 0), 64'(1));
      if (exp_aw.size() != 0) cmp("aw_payload", 64'(mst_req.aw), 64'(exp_aw.pop_front()));
    end
    if (mst_req.ar_valid && mst_rsp.ar_ready) begin
      cmp("ar_avail", 64'(exp_ar.size() != 0), 64'(1));
      if (exp_ar.size() != 0) cmp("ar_payload", 64'(mst_req.ar), 64'(exp_ar.pop_front()));
    end
    if (mst_req.w_valid && mst_rsp.w_ready) begin
      cmp("w_avail", 64'(exp_w.size() != 0), 64'(1));
      if (exp_w.size() != 0) cmp("w_payload", 64'(mst_req.w), 64'(exp_w.pop_front()));
    end
    if (slv_rsp.b_valid && slv_req.b_ready) begin
      cmp("b_avail", 64'(exp_b.size() != 0), 64'(1));
      if (exp_b.size() != 0) cmp("b_payload", 64'(slv_rsp.b), 64'(exp_b.pop_front()));
    end
    if (slv_rsp.r_valid && slv_req.r_ready) begin
      cmp("r_avail", 64'(exp_r.size() != 0), 64'(1));
      if (exp_r.size() != 0) cmp("r_payload", 64'(slv_rsp.r), 64'(exp_r.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    isolate = 1'b0;
    slv_req = '0;
    mst_rsp = '0;
    slv_req.b_ready = 1'b1;
    slv_req.r_ready = 1'b1;
    mst_rsp.aw_ready = 1'b1;
    mst_rsp.w_ready = 1'b1;
    mst_rsp.ar_ready = 1'b1;
    repeat (2) tick;
    rst = 1'b0;
    // pass-through: AW len=3 with its first W beat in the same cycle
    slv_req.aw = ax(4'd1, 32'h1000, 8'd3);
    slv_req.aw_valid = 1'b1;
    exp_aw.push_back(slv_req.aw);
    slv_req.w = wb(32'h100, 1'b0);
    slv_req.w_valid = 1'b1;
    exp_w.push_back(slv_req.w);
    neg;
    cmp("rst_isolated", 64'(isolated), 64'(0));
    cmp("rst_wr_cnt", 64'(dut.wr_cnt), 64'(0));
    cmp("rst_rd_cnt", 64'(dut.rd_cnt), 64'(0));
    cmp("rst_w_pend", 64'(dut.w_pend), 64'(0));
    cmp("w_wait_aw", 64'(mst_req.w_valid), 64'(0));
    cmp("aw_pass", 64'(mst_req.aw_valid), 64'(1));
    tick;
    slv_req.aw_valid = 1'b0;
    neg;
    cmp("w_fwd_1cyc", 64'(mst_req.w_valid), 64'(1));
    tick;
    for (int i = 1; i < 4; i++) begin
      slv_req.w = wb(32'h100 + 32'(i), i == 3);
      exp_w.push_back(slv_req.w);
      tick;
    end
    slv_req.w_valid = 1'b0;
    mst_rsp.b = bb(4'd1);
    mst_rsp.b_valid = 1'b1;
    exp_b.push_back(mst_rsp.b);
    tick;
    mst_rsp.b_valid = 1'b0;
    slv_req.ar = ax(4'd2, 32'h2000, 8'd1);
    slv_req.ar_valid = 1'b1;
    exp_ar.push_back(slv_req.ar);
    tick;
    slv_req.ar_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mst_rsp.r = rb(4'd2, 32'h200 + 32'(i), i == 1);
      mst_rsp.r_valid = 1'b1;
      exp_r.push_back(mst_rsp.r);
      tick;
    end
    mst_rsp.r_valid = 1'b0;
    neg;
    cmp("pt_wr_cnt", 64'(dut.wr_cnt), 64'(0));
    cmp("pt_rd_cnt", 64'(dut.rd_cnt), 64'(0));
    cmp("pt_w_pend", 64'(dut.w_pend), 64'(0));
    tick;
    // outstanding cap: five ARs with R held back
    for (int k = 0; k < 4; k++) begin
      slv_req.ar = ax(4'd3, 32'h3000 + 32'(16 * k), 8'd0);
      slv_req.ar_valid = 1'b1;
      exp_ar.push_back(slv_req.ar);
      neg;
      cmp("cap_ar_ready", 64'(slv_rsp.ar_ready), 64'(1));
      tick;
    end
    slv_req.ar = ax(4'd3, 32'h3040, 8'd0);
    exp_ar.push_back(slv_req.ar);
    neg;
    cmp("cap_block", 64'(slv_rsp.ar_ready), 64'(0));
    cmp("cap_block_mst", 64'(mst_req.ar_valid), 64'(0));
    tick;
    mst_rsp.r = rb(4'd3, 32'h300, 1'b1);
    mst_rsp.r_valid = 1'b1;
    exp_r.push_back(mst_rsp.r);
    neg;
    cmp("cap_block_r", 64'(slv_rsp.ar_ready), 64'(0));
    tick;
    mst_rsp.r_valid = 1'b0;
    neg;
    cmp("cap_release", 64'(slv_rsp.ar_ready), 64'(1));
    tick;
    slv_req.ar_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      mst_rsp.r = rb(4'd3, 32'h300 + 32'(k), 1'b1);
      mst_rsp.r_valid = 1'b1;
      exp_r.push_back(mst_rsp.r);
      tick;
    end
    mst_rsp.r_valid = 1'b0;
    neg;
    cmp("cap_rd_cnt", 64'(dut.rd_cnt), 64'(0));
    tick;
    // drain: two writes awaiting B
    slv_req.aw = ax(4'd4, 32'h4000, 8'd0);
    slv_req.aw_valid = 1'b1;
    exp_aw.push_back(slv_req.aw);
    tick;
    slv_req.aw = ax(4'd5, 32'h4100, 8'd0);
    exp_aw.push_back(slv_req.aw);
    slv_req.w = wb(32'h40, 1'b1);
    slv_req.w_valid = 1'b1;
    exp_w.push_back(slv_req.w);
    tick;
    slv_req.aw_valid = 1'b0;
    slv_req.w = wb(32'h41, 1'b1);
    exp_w.push_back(slv_req.w);
    tick;
    slv_req.w_valid = 1'b0;
    isolate = 1'b1;
    tick;
    slv_req.aw = ax(4'd6, 32'h4200, 8'd0);
    slv_req.aw_valid = 1'b1;
    neg;
    cmp("drain_aw_ready", 64'(slv_rsp.aw_ready), 64'(0));
    cmp("drain_aw_valid", 64'(mst_req.aw_valid), 64'(0));
    cmp("drain_not_iso", 64'(isolated), 64'(0));
    tick;
    mst_rsp.b = bb(4'd4);
    mst_rsp.b_valid = 1'b1;
    exp_b.push_back(mst_rsp.b);
    tick;
    mst_rsp.b = bb(4'd5);
    exp_b.push_back(mst_rsp.b);
    neg;
    cmp("drain_b2_iso", 64'(isolated), 64'(0));
    tick;
    mst_rsp.b_valid = 1'b0;
    neg;
    cmp("drain_iso_early", 64'(isolated), 64'(0));
    tick;
    neg;
    cmp("drain_iso", 64'(isolated), 64'(1));
    cmp("iso_aw_block", 64'(mst_req.aw_valid), 64'(0));
    tick;
    slv_req.aw_valid = 1'b0;
    isolate = 1'b0;
    tick;
    neg;
    cmp("iso_release", 64'(isolated), 64'(0));
    tick;
    // pending W: AW accepted, isolate before its data
    slv_req.aw = ax(4'd7, 32'h5000, 8'd1);
    slv_req.aw_valid = 1'b1;
    exp_aw.push_back(slv_req.aw);
    tick;
    slv_req.aw_valid = 1'b0;
    isolate = 1'b1;
    tick;
    slv_req.w = wb(32'h50, 1'b0);
    slv_req.w_valid = 1'b1;
    exp_w.push_back(slv_req.w);
    neg;
    cmp("pend_w_fwd", 64'(mst_req.w_valid), 64'(1));
    tick;
    slv_req.w = wb(32'h51, 1'b1);
    exp_w.push_back(slv_req.w);
    tick;
    slv_req.w_valid = 1'b0;
    neg;
    cmp("pend_no_iso_w", 64'(isolated), 64'(0));
    tick;
    mst_rsp.b = bb(4'd7);
    mst_rsp.b_valid = 1'b1;
    exp_b.push_back(mst_rsp.b);
    tick;
    mst_rsp.b_valid = 1'b0;
    neg;
    cmp("pend_no_iso_b", 64'(isolated), 64'(0));
    tick;
    neg;
    cmp("pend_iso", 64'(isolated), 64'(1));
    tick;
    isolate = 1'b0;
    tick;
    // abort drain with one read outstanding
    slv_req.ar = ax(4'd8, 32'h6000, 8'd0);
    slv_req.ar_valid = 1'b1;
    exp_ar.push_back(slv_req.ar);
    tick;
    slv_req.ar_valid = 1'b0;
    isolate = 1'b1;
    tick;
    slv_req.ar = ax(4'd9, 32'h6100, 8'd0);
    slv_req.ar_valid = 1'b1;
    exp_ar.push_back(slv_req.ar);
    for (int i = 0; i < 2; i++) begin
      neg;
      cmp("abort_ar_stall", 64'(slv_rsp.ar_ready), 64'(0));
      cmp("abort_not_iso", 64'(isolated), 64'(0));
      tick;
    end
    isolate = 1'b0;
    neg;
    cmp("abort_ar_stall2", 64'(slv_rsp.ar_ready), 64'(0));
    cmp("abort_not_iso2", 64'(isolated), 64'(0));
    tick;
    neg;
    cmp("abort_ar_accept", 64'(slv_rsp.ar_ready), 64'(1));
    cmp("abort_not_iso3", 64'(isolated), 64'(0));
    tick;
    slv_req.ar_valid = 1'b0;
    mst_rsp.r = rb(4'd8, 32'h60, 1'b1);
    mst_rsp.r_valid = 1'b1;
    exp_r.push_back(mst_rsp.r);
    tick;
    mst_rsp.r = rb(4'd9, 32'h61, 1'b1);
    exp_r.push_back(mst_rsp.r);
    tick;
    mst_rsp.r_valid = 1'b0;
    // reset while isolated with traffic waiting upstream
    isolate = 1'b1;
    tick;
    tick;
    neg;
    cmp("rst6_iso", 64'(isolated), 64'(1));
    tick;
    slv_req.aw = ax(4'd10, 32'h7000, 8'd0);
    slv_req.aw_valid = 1'b1;
    exp_aw.push_back(slv_req.aw);
    slv_req.ar = ax(4'd11, 32'h7100, 8'd0);
    slv_req.ar_valid = 1'b1;
    exp_ar.push_back(slv_req.ar);
    slv_req.w = wb(32'h70, 1'b1);
    slv_req.w_valid = 1'b1;
    exp_w.push_back(slv_req.w);
    rst = 1'b1;
    isolate = 1'b0;
    tick;
    rst = 1'b0;
    neg;
    cmp("rst6_isolated", 64'(isolated), 64'(0));
    cmp("rst6_wr_cnt", 64'(dut.wr_cnt), 64'(0));
    cmp("rst6_rd_cnt", 64'(dut.rd_cnt), 64'(0));
    cmp("rst6_aw_ready", 64'(slv_rsp.aw_ready), 64'(1));
    cmp("rst6_ar_ready", 64'(slv_rsp.ar_ready), 64'(1));
    cmp("rst6_w_block", 64'(mst_req.w_valid), 64'(0));
    tick;
    slv_req.aw_valid = 1'b0;
    slv_req.ar_valid = 1'b0;
    neg;
    cmp("rst6_w_fwd", 64'(mst_req.w_valid), 64'(1));
    tick;
    slv_req.w_valid = 1'b0;
    mst_rsp.b = bb(4'd10);
    mst_rsp.b_valid = 1'b1;
    exp_b.push_back(mst_rsp.b);
    mst_rsp.r = rb(4'd11, 32'h71, 1'b1);
    mst_rsp.r_valid = 1'b1;
    exp_r.push_back(mst_rsp.r);
    tick;
    mst_rsp.b_valid = 1'b0;
    mst_rsp.r_valid = 1'b0;
    neg;
    cmp("end_queues", 64'(exp_aw.size() + exp_ar.size() + exp_w.size() + exp_b.size() + exp_r.size()), 64'(0));
    cmp("end_wr_cnt", 64'(dut.wr_cnt), 64'(0));
    cmp("end_rd_cnt", 64'(dut.rd_cnt), 64'(0));
    cmp("end_w_pend", 64'(dut.w_pend), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
